// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for one uPower instruction at a time.
// Define PERF_COUNTERS_EN to add the cyc_cnt/instr_cnt performance counters (and CNT_W).
module upower_multicycle_sequencer #(
  parameter int WAIT_MAX = 16
`ifdef PERF_COUNTERS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       reg_read,
  input  logic       reg_write,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       branch,
  input  logic       mem_to_reg,
  input  logic       alu_src,
  input  logic       pc_src,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_load,
  output logic       rf_re,
  output logic       rf_we,
  output logic       rf_wsel_mem,
  output logic       alu_src_imm,
  output logic       pc_write,
  output logic       pc_sel_branch,
  output logic       busy,
  output logic [2:0] state_o,
  output logic       illegal_op,
  output logic       timeout_err
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // Trap fires in the cycle the counter sits at WAIT_MAX-1 without ready.
  localparam logic [WCW-1:0] WLAST = WCW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t         state, state_nx;
  logic [WCW-1:0] wcnt;
  logic           wait_hit, legal, set_ill, set_tmo;

  assign legal    = reg_write | mem_read | mem_write | branch;
  assign wait_hit = (WAIT_MAX > 0) && (wcnt == WLAST);
  assign state_o  = state;

  always_comb begin
    state_nx      = state;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_load       = 1'b0;
    rf_re         = 1'b0;
    rf_we         = 1'b0;
    rf_wsel_mem   = 1'b0;
    alu_src_imm   = 1'b0;
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    busy          = 1'b0;
    set_ill       = 1'b0;
    set_tmo       = 1'b0;
    // Enables are suppressed during reset so an aborted instruction never commits.
    if (rst_n) begin
      busy = (state != S_IDLE) && (state != S_TRAP);
      case (state)
        S_IDLE: if (run) state_nx = S_FETCH;
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load  = 1'b1;
            state_nx = S_DECODE;
          end else if (wait_hit) begin
            set_tmo  = 1'b1;
            state_nx = S_TRAP;
          end
        end
        S_DECODE: begin
          rf_re = reg_read;
          if (legal) state_nx = S_EXEC;
          else begin
            set_ill  = 1'b1;
            state_nx = S_TRAP;
          end
        end
        S_EXEC: begin
          rf_re       = reg_read;
          alu_src_imm = alu_src;
          if (branch) begin
            pc_write      = 1'b1;
            pc_sel_branch = pc_src & (br_taken | ~reg_read);
            state_nx      = S_IDLE;
          end else if (mem_read || mem_write) state_nx = S_MEM;
          else state_nx = S_WB;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ready) begin
            if (mem_write) begin
              pc_write = 1'b1;
              state_nx = S_IDLE;
            end else state_nx = S_WB;
          end else if (wait_hit) begin
            set_tmo  = 1'b1;
            state_nx = S_TRAP;
          end
        end
        S_WB: begin
          rf_we       = 1'b1;
          rf_wsel_mem = mem_to_reg;
          pc_write    = 1'b1;
          state_nx    = S_IDLE;
        end
        S_TRAP:  state_nx = S_TRAP;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) wcnt <= '0;
      else if (state == S_FETCH || state == S_MEM) wcnt <= wcnt + 1'b1;
      if (set_ill) illegal_op <= 1'b1;
      if (set_tmo) timeout_err <= 1'b1;
    end
  end

`ifdef PERF_COUNTERS_EN
  // busy and pc_write are both zero in TRAP, so the counters freeze there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) cyc_cnt <= cyc_cnt + 1'b1;
      if (pc_write) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_upower_multicycle_sequencer.sv
// Bench for upower_multicycle_sequencer: directed vector table, corner sequences,
// and random instructions checked against an instruction-level reference model.
module tb_upower_multicycle_sequencer;
  localparam int WM = 4;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic reg_read = 0, reg_write = 0, mem_read = 0, mem_write = 0, branch = 0;
  logic mem_to_reg = 0, alu_src = 0, pc_src = 0, br_taken = 0;
  logic imem_ready = 0, dmem_ready = 0;
  logic imem_req, dmem_req, dmem_we, ir_load, rf_re, rf_we, rf_wsel_mem;
  logic alu_src_imm, pc_write, pc_sel_branch, busy, illegal_op, timeout_err;
  logic [2:0] state_o;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  upower_multicycle_sequencer #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .reg_read(reg_read), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .pc_src(pc_src), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_load(ir_load), .rf_re(rf_re), .rf_we(rf_we), .rf_wsel_mem(rf_wsel_mem),
    .alu_src_imm(alu_src_imm), .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .busy(busy), .state_o(state_o), .illegal_op(illegal_op), .timeout_err(timeout_err)
`ifdef PERF_COUNTERS_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // ctl = {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src}
  typedef struct {
    logic [7:0] ctl;
    logic       bt;
    int         fw;  // fetch wait cycles before imem_ready
    int         dw;  // data wait cycles before dmem_ready
  } stim_t;

  typedef struct {
    logic [63:0] trace;  // state_o per cycle, octal digits, oldest first
    int busy, imem, dmem, dwe, rfre, rfwe, pcw, irl, aimm;
    logic wsel, pcsel, ill, tmo;
  } obs_t;

  typedef struct {
    stim_t s;
    logic [63:0] trace;
    int busy, imem, dmem, rfwe, pcw;
    logic wsel, pcsel, ill, tmo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] push(logic [63:0] t, int st, int n);
    for (int i = 0; i < n; i++) t = (t << 3) | 64'(st);
    return t;
  endfunction

  // Instruction-level reference: walks the phases an instruction needs and
  // accumulates what each phase contributes to the observable totals.
  function automatic obs_t model(stim_t s);
    obs_t e;
    logic rr, rw, mr, mw, br, m2r, as_, ps;
    e = '{default: 0};
    {rr, rw, mr, mw, br, m2r, as_, ps} = s.ctl;
    if (s.fw >= WM) begin
      e.trace = push(push(0, 1, WM), 7, 1);
      e.imem = WM; e.busy = WM; e.tmo = 1;
      return e;
    end
    e.trace = push(0, 1, s.fw + 1);
    e.imem = s.fw + 1; e.irl = 1; e.busy = s.fw + 1;
    e.trace = push(e.trace, 2, 1); e.busy++; e.rfre += int'(rr);
    if (!(rw | mr | mw | br)) begin
      e.trace = push(e.trace, 7, 1); e.ill = 1;
      return e;
    end
    e.trace = push(e.trace, 3, 1); e.busy++; e.rfre += int'(rr); e.aimm = int'(as_);
    if (br) begin
      e.pcw = 1; e.pcsel = ps & (s.bt | ~rr);
      e.trace = push(e.trace, 0, 1);
      return e;
    end
    if (mr | mw) begin
      if (s.dw >= WM) begin
        e.trace = push(push(e.trace, 4, WM), 7, 1);
        e.busy += WM; e.dmem = WM; e.dwe = mw ? WM : 0; e.tmo = 1;
        return e;
      end
      e.trace = push(e.trace, 4, s.dw + 1);
      e.busy += s.dw + 1; e.dmem = s.dw + 1; e.dwe = mw ? s.dw + 1 : 0;
      if (mw) begin
        e.pcw = 1; e.trace = push(e.trace, 0, 1);
        return e;
      end
    end
    e.trace = push(push(e.trace, 5, 1), 0, 1);
    e.busy++; e.rfwe = 1; e.wsel = m2r; e.pcw = 1;
    return e;
  endfunction

  function automatic vec_t mkv(logic [7:0] ctl, logic bt, int fw, int dw, logic [63:0] tr,
                               int bz, int im, int dm, int rw, logic ws, int pw,
                               logic ps, logic il, logic to);
    vec_t v;
    v.s = '{ctl: ctl, bt: bt, fw: fw, dw: dw};
    v.trace = tr; v.busy = bz; v.imem = im; v.dmem = dm; v.rfwe = rw;
    v.wsel = ws; v.pcw = pw; v.pcsel = ps; v.ill = il; v.tmo = to;
    return v;
  endfunction

  // Starts at posedge+1 with the DUT in IDLE; pulses run for one cycle only.
  task automatic run_instr(input stim_t s, output obs_t o);
    int fc, dc;
    bit done;
    o = '{default: 0}; fc = 0; dc = 0; done = 0;
    {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src} = s.ctl;
    br_taken = s.bt;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      imem_ready = imem_req && (fc == s.fw);
      if (imem_req) fc++;
      dmem_ready = dmem_req && (dc == s.dw);
      if (dmem_req) dc++;
      @(negedge clk);
      o.trace = (o.trace << 3) | 64'(state_o);
      o.busy += int'(busy); o.imem += int'(imem_req); o.dmem += int'(dmem_req);
      o.dwe += int'(dmem_req & dmem_we); o.rfre += int'(rf_re);
      o.irl += int'(ir_load); o.aimm += int'(alu_src_imm);
      if (rf_we) begin o.rfwe++; o.wsel = rf_wsel_mem; end
      if (pc_write) begin o.pcw++; o.pcsel = pc_sel_branch; end
      if (state_o == 3'd0 || state_o == 3'd7) begin
        done = 1; o.ill = illegal_op; o.tmo = timeout_err;
      end
      @(posedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    chk("instr_completes", 64'(done), 64'd1);
  endtask

  task automatic cmp_obs(input string t, input obs_t o, input obs_t e);
    chk({t, ".trace"}, o.trace, e.trace);
    chk({t, ".busy"}, 64'(o.busy), 64'(e.busy));
    chk({t, ".imem"}, 64'(o.imem), 64'(e.imem));
    chk({t, ".dmem"}, 64'(o.dmem), 64'(e.dmem));
    chk({t, ".dmem_we"}, 64'(o.dwe), 64'(e.dwe));
    chk({t, ".rf_re"}, 64'(o.rfre), 64'(e.rfre));
    chk({t, ".rf_we"}, 64'(o.rfwe), 64'(e.rfwe));
    chk({t, ".wsel"}, 64'(o.wsel), 64'(e.wsel));
    chk({t, ".pc_write"}, 64'(o.pcw), 64'(e.pcw));
    chk({t, ".pc_sel"}, 64'(o.pcsel), 64'(e.pcsel));
    chk({t, ".ir_load"}, 64'(o.irl), 64'(e.irl));
    chk({t, ".alu_imm"}, 64'(o.aimm), 64'(e.aimm));
    chk({t, ".illegal"}, 64'(o.ill), 64'(e.ill));
    chk({t, ".timeout"}, 64'(o.tmo), 64'(e.tmo));
  endtask

  // Called at posedge+1 in TRAP: run must be ignored, then a 1-cycle reset clears it.
  task automatic trap_reset(input string t);
    run = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({t, ".trap_hold"}, 64'(state_o), 64'd7);
    chk({t, ".trap_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    run = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk({t, ".rst_state"}, 64'(state_o), 64'd0);
    chk({t, ".rst_flags"}, 64'({illegal_op, timeout_err}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[$];
    obs_t  o;
    stim_t s;
    logic [63:0] tr;
    int pw;

    tbl.push_back(mkv(8'b1100_0000, 0, 0, 0, 64'o12350,     4, 1, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b1010_0110, 0, 0, 3, 64'o123444450, 8, 1, 4, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b1000_1001, 0, 0, 0, 64'o1230,      3, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b1000_1001, 1, 0, 0, 64'o1230,      3, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mkv(8'b1001_0010, 0, 0, 1, 64'o123440,    5, 1, 2, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b0000_1001, 0, 0, 0, 64'o1230,      3, 1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mkv(8'b1100_0000, 0, 2, 0, 64'o1112350,   6, 3, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b1100_0000, 0, 3, 0, 64'o11112350,  7, 4, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(8'b1100_0000, 0, 4, 0, 64'o11117,     4, 4, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(8'b0000_0000, 0, 0, 0, 64'o127,       2, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv(8'b1010_0100, 0, 0, 4, 64'o12344447,  7, 1, 4, 0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.imem_req", 64'(imem_req), 64'd0);
    chk("rst.pc_write", 64'(pc_write), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.state", 64'(state_o), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.flags", 64'({illegal_op, timeout_err}), 64'd0);
`ifdef PERF_COUNTERS_EN
    chk("rst.cyc_cnt", 64'(cyc_cnt), 64'd0);
    chk("rst.instr_cnt", 64'(instr_cnt), 64'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_instr(tbl[i].s, o);
      chk({nm, ".trace"}, o.trace, tbl[i].trace);
      chk({nm, ".busy"}, 64'(o.busy), 64'(tbl[i].busy));
      chk({nm, ".imem"}, 64'(o.imem), 64'(tbl[i].imem));
      chk({nm, ".dmem"}, 64'(o.dmem), 64'(tbl[i].dmem));
      chk({nm, ".rf_we"}, 64'(o.rfwe), 64'(tbl[i].rfwe));
      chk({nm, ".wsel"}, 64'(o.wsel), 64'(tbl[i].wsel));
      chk({nm, ".pc_write"}, 64'(o.pcw), 64'(tbl[i].pcw));
      chk({nm, ".pc_sel"}, 64'(o.pcsel), 64'(tbl[i].pcsel));
      chk({nm, ".illegal"}, 64'(o.ill), 64'(tbl[i].ill));
      chk({nm, ".timeout"}, 64'(o.tmo), 64'(tbl[i].tmo));
`ifdef PERF_COUNTERS_EN
      if (i == 0) begin
        chk("vec0.cyc_cnt", 64'(cyc_cnt), 64'd4);
        chk("vec0.instr_cnt", 64'(instr_cnt), 64'd1);
      end
`endif
      if (tbl[i].ill || tbl[i].tmo) trap_reset(nm);
    end

    // run held high: back-to-back ALU ops, one per 5-cycle period
    {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src} = 8'b1100_0000;
    imem_ready = 1'b1; dmem_ready = 1'b1; run = 1'b1;
    tr = '0; pw = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      tr = (tr << 3) | 64'(state_o);
      pw += int'(pc_write);
    end
    run = 1'b0;
    chk("b2b.trace", tr, 64'o1235012350);
    chk("b2b.pc_write", 64'(pw), 64'd2);
    @(posedge clk); #1;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    chk("b2b.idle_hold", 64'(state_o), 64'd0);
    @(posedge clk); #1;

    // reset while a data request is outstanding
    {reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src} = 8'b1010_0100;
    imem_ready = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int c = 0; c < 10 && !dmem_req; c++) begin
      @(posedge clk); #1;
    end
    chk("mrst.reach_mem", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.no_commit", 64'({pc_write, rf_we, dmem_req}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    chk("mrst.state", 64'(state_o), 64'd0);
    chk("mrst.outputs", 64'({imem_req, dmem_req, dmem_we, ir_load, rf_re, rf_we, rf_wsel_mem,
                            alu_src_imm, pc_write, pc_sel_branch, busy, illegal_op, timeout_err}), 64'd0);
`ifdef PERF_COUNTERS_EN
    chk("mrst.cyc_cnt", 64'(cyc_cnt), 64'd0);
    chk("mrst.instr_cnt", 64'(instr_cnt), 64'd0);
`endif
    @(posedge clk); #1;

    // random instructions against the reference model
    for (int n = 0; n < 80; n++) begin
      obs_t e;
      string nm;
      s.ctl = 8'($urandom_range(0, 255));
      s.bt  = 1'($urandom_range(0, 1));
      s.fw  = ($urandom_range(0, 9) == 0) ? WM : int'($urandom_range(0, 3));
      s.dw  = ($urandom_range(0, 9) == 0) ? WM : int'($urandom_range(0, 3));
      nm = $sformatf("rnd%0d", n);
      e = model(s);
      run_instr(s, o);
      cmp_obs(nm, o, e);
      if (e.ill || e.tmo) trap_reset(nm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upower_multicycle_sequencer.md
Name: upower_multicycle_sequencer

Overview:
Multi-cycle FSM that sequences one uPower instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It consumes the per-instruction control signals produced by control_unit and drives the per-cycle enables for the IR, register file, ALU operand mux, data memory and PC. It owns the instruction- and data-memory handshakes, bounds memory waits with a timeout, and traps on undecodable instructions.

Parameters:
WAIT_MAX, 16, max cycles a memory request may stay unanswered before a timeout trap; 0 disables the timeout.
CNT_W, 32, width of the performance counters (Optional Feature only).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
run  in  1  level; when high in IDLE, the next instruction is fetched
reg_read, reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src, pc_src  in  1 each  decoded controls from control_unit; valid from DECODE onward
br_taken  in  1  branch condition from ALU; valid in EXEC
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load; valid while dmem_req=1
dmem_ready  in  1  data access complete this cycle
ir_load  out  1  latch instruction register
rf_re  out  1  register file read enable
rf_we  out  1  register file write enable, one-cycle pulse
rf_wsel_mem  out  1  write-data mux: 1=memory, 0=ALU
alu_src_imm  out  1  ALU operand B = immediate
pc_write  out  1  PC update pulse
pc_sel_branch  out  1  PC source: 1=branch target, 0=PC+4; valid with pc_write
busy  out  1  high in every state except IDLE and TRAP
state_o  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
illegal_op  out  1  sticky; set on trap by undecodable instruction
timeout_err  out  1  sticky; set on trap by memory timeout

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; wait counter 0; sticky flags cleared. Reset mid-instruction aborts immediately, including an outstanding request; no pc_write or rf_we is issued.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH: imem_req=1 held until imem_ready. In the imem_ready cycle, ir_load=1 and next state is DECODE. Zero-wait memory gives a 1-cycle FETCH.
- DECODE (1 cycle): rf_re=reg_read. Classification:
  - any of reg_write, mem_read, mem_write or branch set -> EXEC;
  - none set -> TRAP with illegal_op=1.
- EXEC (1 cycle): alu_src_imm=alu_src; rf_re=reg_read.
  - branch=1: pc_write=1, pc_sel_branch=pc_src & (br_taken | ~reg_read). Unconditional branches (reg_read=0) are always taken. Next state IDLE.
  - mem_read or mem_write: next state MEM.
  - otherwise: next state WB.
- MEM: dmem_req=1, dmem_we=mem_write (mem_write wins if both set), held until dmem_ready. In the dmem_ready cycle:
  - store: pc_write=1, pc_sel_branch=0, next state IDLE;
  - load: next state WB.
- WB (1 cycle): rf_we=1, rf_wsel_mem=mem_to_reg, pc_write=1, pc_sel_branch=0, next state IDLE.
  - Loads write back even though control_unit deasserts reg_write for them (mem_read implies write-back).
- Latency, zero-wait memory, IDLE to IDLE: branch 4 cycles, ALU 5, store 5, load 6. With run held high, one instruction starts every latency period.
- Timeout: the wait counter resets on entry to FETCH or MEM and increments each cycle the request is held without ready. If the counter reaches WAIT_MAX (WAIT_MAX>0), go to TRAP with timeout_err=1 and drop the request. A ready in the same cycle as the limit wins: no trap.
- TRAP: all enables 0; busy=0; stays until reset. run is ignored.
- Dropping run mid-instruction has no effect; the current instruction completes and the FSM then holds in IDLE.
- Control inputs are sampled combinationally in each state; the team's decode stage holds them stable from DECODE until return to IDLE.

Optional Feature:
PERF_COUNTERS_EN: adds outputs cyc_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
- cyc_cnt increments on every cycle with busy=1.
- instr_cnt increments on every pc_write pulse.
- Both wrap modulo 2^CNT_W, reset to 0 and freeze in TRAP.
Without the macro, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- ALU op (reg_write=1, reg_read=1), zero-wait memory, run=1 -> state_o 1,2,3,5,0; one rf_we pulse with rf_wsel_mem=0; pc_write with pc_sel_branch=0 in WB.
- Load (mem_read=1, mem_to_reg=1, reg_write=0), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; rf_we=1 and rf_wsel_mem=1 in WB; 9 cycles IDLE to IDLE.
- Conditional branch (branch=1, pc_src=1, reg_read=1): br_taken=0 -> pc_sel_branch=0; br_taken=1 -> pc_sel_branch=1. Both cases: pc_write in EXEC, no rf_we, back in IDLE after 4 cycles.
- WAIT_MAX=4, imem_ready never asserted -> imem_req high 4 cycles, then state_o=7, timeout_err=1, busy=0. Repeat with imem_ready on the 4th cycle -> no trap.
- All control inputs 0 in DECODE -> TRAP, illegal_op=1, no pc_write/rf_we; rst_n=0 for one cycle -> state_o=0, flags cleared.
- rst_n=0 while dmem_req=1 -> next cycle all outputs 0, state_o=0; with PERF_COUNTERS_EN, both counters read 0.
